dbgnoc_fifo_vc_arbiter: RTL and testbench

//  Shares the single 16-bit host FIFO (GLIP fifo_in side) between the debug NoC virtual channels
//  (conf VC 0, trace VC 1, ...). Arbitrates round-robin at packet granularity and never interleaves

---
 rtl/dbgnoc_fifo_pkg.sv | 23 ++
 rtl/lisnoc_arb_rr.sv | 42 ++++
 rtl/dbgnoc_fifo_vc_arbiter.sv | 124 ++++++++++++
 tb/tb_dbgnoc_fifo_vc_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbgnoc_fifo_pkg.sv
// dbgnoc_fifo_pkg: flit type codes, tag format and FSM states shared by the host FIFO mux/demux.
// Rev 1.0
`default_nettype none

package dbgnoc_fifo_pkg;

  localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

  localparam logic [11:0] TAG_PREFIX_DEFAULT = 12'hDB0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;

  function automatic logic [15:0] make_tag(input logic [11:0] prefix, input logic [3:0] vc);
    return {prefix, vc};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lisnoc_arb_rr.sv
// lisnoc_arb_rr: combinational round-robin pick, first requester strictly after 'last', wrapping.
// Rev 1.0
`default_nettype none

module lisnoc_arb_rr #(
  parameter int VCHANNELS = 2
) (
  input  logic [VCHANNELS-1:0] req,
  input  logic [3:0]           last,
  output logic [3:0]           grant,
  output logic                 found
);

  logic       found_hi;
  logic       found_lo;
  logic [3:0] grant_hi;
  logic [3:0] grant_lo;

  // Requesters above 'last' take precedence; the rest wrap around from index 0.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = 4'd0;
    grant_lo = 4'd0;
    for (int i = 0; i < VCHANNELS; i++) begin
      if (req[i] && !found_hi && (i > int'(last))) begin
        found_hi = 1'b1;
        grant_hi = 4'(i);
      end
      if (req[i] && !found_lo && (i <= int'(last))) begin
        found_lo = 1'b1;
        grant_lo = 4'(i);
      end
    end
  end

  assign found = found_hi | found_lo;
  assign grant = found_hi ? grant_hi : grant_lo;

endmodule

`default_nettype wire

// File: rtl/dbgnoc_fifo_vc_arbiter.sv
// dbgnoc_fifo_vc_arbiter: packet-granular round-robin mux of debug NoC VCs onto the host FIFO,
// each packet prefixed with a VC tag word. Rev 1.0
`default_nettype none

module dbgnoc_fifo_vc_arbiter
  import dbgnoc_fifo_pkg::*;
#(
  parameter int          VCHANNELS       = 2,
  parameter int          FLIT_DATA_WIDTH = 16,
  parameter int          FLIT_TYPE_WIDTH = 2,
  parameter logic [11:0] TAG_PREFIX      = TAG_PREFIX_DEFAULT
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush,
  input  logic [FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0]                     in_valid,
  output logic [VCHANNELS-1:0]                     in_ready,
  output logic [FLIT_DATA_WIDTH-1:0]               fifo_out_data,
  output logic                                     fifo_out_valid,
  input  logic                                     fifo_out_ready,
  output logic                                     busy,
  output logic [3:0]                               cur_vc,
  output logic                                     proto_err
);

  logic [0:0]                 state;
  logic [3:0]                 rr_last;
  logic                       first;
  logic                       can_load;
  logic                       arb_found;
  logic [3:0]                 arb_grant;
  logic [1:0]                 ftype;
  logic                       start;
  logic                       xfer;
  logic                       is_end;
  logic                       bad_type;
  logic                       load;
  logic [FLIT_DATA_WIDTH-1:0] load_data;

  lisnoc_arb_rr #(
    .VCHANNELS (VCHANNELS)
  ) u_arb (
    .req   (in_valid),
    .last  (rr_last),
    .grant (arb_grant),
    .found (arb_found)
  );

  assign can_load = !fifo_out_valid || fifo_out_ready;
  assign ftype    = in_flit[FLIT_DATA_WIDTH +: 2];

  // Only the granted VC ever sees ready, so flits of two packets cannot interleave.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < VCHANNELS; i++) begin
      if ((state == ST_FWD) && can_load && !flush && (cur_vc == 4'(i)))
        in_ready[i] = 1'b1;
    end
  end

  assign start    = (state == ST_IDLE) && arb_found && can_load && !flush;
  assign xfer     = |(in_valid & in_ready);
  assign is_end   = (ftype == FLIT_TYPE_LAST) || (ftype == FLIT_TYPE_SINGLE);
  assign bad_type = first ? ((ftype == FLIT_TYPE_PAYLOAD) || (ftype == FLIT_TYPE_LAST))
                          : ((ftype == FLIT_TYPE_HEADER)  || (ftype == FLIT_TYPE_SINGLE));
  assign load      = start || xfer;
  assign load_data = start ? FLIT_DATA_WIDTH'(make_tag(TAG_PREFIX, arb_grant))
                           : in_flit[FLIT_DATA_WIDTH-1:0];

  assign busy = (state == ST_FWD) || fifo_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      fifo_out_valid <= 1'b0;
      fifo_out_data  <= '0;
      cur_vc         <= 4'd0;
      first          <= 1'b0;
      proto_err      <= 1'b0;
      rr_last        <= 4'(VCHANNELS - 1);
    end else if (flush) begin
      state          <= ST_IDLE;
      fifo_out_valid <= 1'b0;
      fifo_out_data  <= '0;
      cur_vc         <= 4'd0;
      first          <= 1'b0;
      proto_err      <= 1'b0;
      rr_last        <= 4'(VCHANNELS - 1);
    end else begin
      if (load) begin
        fifo_out_data  <= load_data;
        fifo_out_valid <= 1'b1;
      end else if (fifo_out_ready) begin
        fifo_out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_vc <= arb_grant;
            first  <= 1'b1;
            state  <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (xfer) begin
            first <= 1'b0;
            if (bad_type)
              proto_err <= 1'b1;
            if (is_end) begin
              rr_last <= cur_vc;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dbgnoc_fifo_vc_arbiter.sv
// tb_dbgnoc_fifo_vc_arbiter: directed-vector bench for the host FIFO VC arbiter.
// Rev 1.0
`default_nettype none

module tb_dbgnoc_fifo_vc_arbiter;
  import dbgnoc_fifo_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [17:0] in_flit;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [15:0] fifo_out_data;
  logic        fifo_out_valid;
  logic        fifo_out_ready;
  logic        busy;
  logic [3:0]  cur_vc;
  logic        proto_err;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rdy0_cycles = 0;
  logic flush_req  = 1'b0;
  logic host_ready = 1'b1;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [15:0] outq[$];
  int          outcyc[$];

  dbgnoc_fifo_vc_arbiter #(
    .VCHANNELS       (2),
    .FLIT_DATA_WIDTH (16),
    .FLIT_TYPE_WIDTH (2),
    .TAG_PREFIX      (12'hDB0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_flit        (in_flit),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fifo_out_data  (fifo_out_data),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ready (fifo_out_ready),
    .busy           (busy),
    .cur_vc         (cur_vc),
    .proto_err      (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock cycle: drive sources/host just after the edge, sample 3 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    flush          = flush_req;
    fifo_out_ready = host_ready;
    in_valid       = {q1.size() > 0, q0.size() > 0};
    #1;
    in_flit = '0;
    if (in_ready[0] && q0.size() > 0)      in_flit = q0[0];
    else if (in_ready[1] && q1.size() > 0) in_flit = q1[0];
    #1;
    cyc++;
    if (in_ready == 2'b11) begin
      errors++;
      $display("FAIL in_ready_onehot: got %b, required at most one bit", in_ready);
    end
    if (in_ready[0]) rdy0_cycles++;
    if (fifo_out_valid && fifo_out_ready) begin
      outq.push_back(fifo_out_data);
      outcyc.push_back(cyc);
    end
    if (in_valid[0] && in_ready[0]) void'(q0.pop_front());
    if (in_valid[1] && in_ready[1]) void'(q1.pop_front());
  endtask

  task automatic drain(input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !busy) && n < max);
    if (n >= max) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic do_flush();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    outq.delete();
    outcyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_flit = '0; in_valid = '0; fifo_out_ready = 1'b1;
    #12;
    vectors++; if (fifo_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", fifo_out_valid); end
    vectors++; if (fifo_out_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h, required 0000", fifo_out_data); end
    vectors++; if (in_ready !== 2'b00) begin errors++; $display("FAIL rst_in_ready: got %b, required 00", in_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    vectors++; if (cur_vc !== 4'd0) begin errors++; $display("FAIL rst_cur_vc: got %0d, required 0", cur_vc); end
    vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b, required 0", proto_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [15:0] exp[$];
    do_flush();
    rdy0_cycles = 0;
    q0.push_back({FLIT_TYPE_SINGLE, 16'h1234});
    step();
    vectors++; if (fifo_out_valid !== 1'b0) begin errors++; $display("FAIL single_lat0_valid: got %b, required 0", fifo_out_valid); end
    step();
    vectors++; if (fifo_out_valid !== 1'b1 || fifo_out_data !== 16'hDB00) begin
      errors++; $display("FAIL single_lat1_tag: got valid=%b data=%h, required 1/DB00", fifo_out_valid, fifo_out_data);
    end
    drain(20);
    exp = '{16'hDB00, 16'h1234};
    vectors++; if (outq.size() !== exp.size()) begin errors++; $display("FAIL single_count: got %0d words, required %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      vectors++; if (outq[i] !== exp[i]) begin errors++; $display("FAIL single_word%0d: got %h, required %h", i, outq[i], exp[i]); end
    end
    vectors++; if (rdy0_cycles !== 1) begin errors++; $display("FAIL single_ready_cycles: got %0d, required 1", rdy0_cycles); end
    vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b, required 0", proto_err); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp[$];
    do_flush();
    q0.push_back({FLIT_TYPE_HEADER,  16'h0A01});
    q0.push_back({FLIT_TYPE_PAYLOAD, 16'h0A02});
    q0.push_back({FLIT_TYPE_LAST,    16'h0A03});
    q1.push_back({FLIT_TYPE_HEADER,  16'h0B01});
    q1.push_back({FLIT_TYPE_PAYLOAD, 16'h0B02});
    q1.push_back({FLIT_TYPE_LAST,    16'h0B03});
    drain(40);
    exp = '{16'hDB00, 16'h0A01, 16'h0A02, 16'h0A03, 16'hDB01, 16'h0B01, 16'h0B02, 16'h0B03};
    vectors++; if (outq.size() !== exp.size()) begin errors++; $display("FAIL b2b_count: got %0d words, required %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      vectors++; if (outq[i] !== exp[i]) begin errors++; $display("FAIL b2b_word%0d: got %h, required %h", i, outq[i], exp[i]); end
    end
    if (outcyc.size() == 8) begin
      vectors++; if (outcyc[7] - outcyc[0] !== 7) begin
        errors++; $display("FAIL b2b_throughput: got span %0d cycles, required 7", outcyc[7] - outcyc[0]);
      end
    end
    vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b, required 0", proto_err); end
  endtask

  task automatic test_stall();
    logic [15:0] exp[$];
    int n = 0;
    do_flush();
    q0.push_back({FLIT_TYPE_HEADER,  16'h0C01});
    q0.push_back({FLIT_TYPE_PAYLOAD, 16'h0C02});
    q0.push_back({FLIT_TYPE_PAYLOAD, 16'h0C03});
    q0.push_back({FLIT_TYPE_LAST,    16'h0C04});
    while (outq.size() < 2 && n < 20) begin step(); n++; end
    host_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (fifo_out_valid !== 1'b1 || fifo_out_data !== 16'h0C02) begin
        errors++; $display("FAIL stall_hold%0d: got valid=%b data=%h, required 1/0C02", k, fifo_out_valid, fifo_out_data);
      end
      vectors++; if (in_ready !== 2'b00) begin errors++; $display("FAIL stall_ready%0d: got %b, required 00", k, in_ready); end
      vectors++; if (busy !== 1'b1 || cur_vc !== 4'd0) begin
        errors++; $display("FAIL stall_frozen%0d: got busy=%b vc=%0d, required 1/0", k, busy, cur_vc);
      end
    end
    host_ready = 1'b1;
    drain(30);
    exp = '{16'hDB00, 16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04};
    vectors++; if (outq.size() !== exp.size()) begin errors++; $display("FAIL stall_count: got %0d words, required %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      vectors++; if (outq[i] !== exp[i]) begin errors++; $display("FAIL stall_word%0d: got %h, required %h", i, outq[i], exp[i]); end
    end
  endtask

  task automatic test_proto_err();
    logic [15:0] exp[$];
    do_flush();
    q1.push_back({FLIT_TYPE_PAYLOAD, 16'h00AA});
    q1.push_back({FLIT_TYPE_LAST,    16'h00AB});
    drain(20);
    exp = '{16'hDB01, 16'h00AA, 16'h00AB};
    vectors++; if (outq.size() !== exp.size()) begin errors++; $display("FAIL perr_count: got %0d words, required %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      vectors++; if (outq[i] !== exp[i]) begin errors++; $display("FAIL perr_word%0d: got %h, required %h", i, outq[i], exp[i]); end
    end
    step(); step();
    vectors++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b, required 1", proto_err); end
    do_flush();
    step();
    vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_flush_clear: got %b, required 0", proto_err); end
  endtask

  task automatic test_flush();
    logic [15:0] exp[$];
    int n = 0;
    do_flush();
    q0.push_back({FLIT_TYPE_HEADER,  16'h0D01});
    q0.push_back({FLIT_TYPE_PAYLOAD, 16'h0D02});
    q0.push_back({FLIT_TYPE_PAYLOAD, 16'h0D03});
    q0.push_back({FLIT_TYPE_LAST,    16'h0D04});
    while (q0.size() > 2 && n < 20) begin step(); n++; end
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    q0.delete();
    step();
    vectors++; if (fifo_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", fifo_out_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: busy got %b, required 0", busy); end
    vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b, required 0", proto_err); end
    outq.delete();
    outcyc.delete();
    q0.push_back({FLIT_TYPE_SINGLE, 16'h0E00});
    q1.push_back({FLIT_TYPE_SINGLE, 16'h0E11});
    drain(20);
    exp = '{16'hDB00, 16'h0E00, 16'hDB01, 16'h0E11};
    vectors++; if (outq.size() !== exp.size()) begin errors++; $display("FAIL flush_tie_count: got %0d words, required %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      vectors++; if (outq[i] !== exp[i]) begin errors++; $display("FAIL flush_tie_word%0d: got %h, required %h", i, outq[i], exp[i]); end
    end
    vectors++; if (proto_err !== 1'b0) begin errors++; $display("FAIL flush_tie_err: got %b, required 0", proto_err); end
  endtask

  task automatic test_fairness();
    logic [15:0] exp[$];
    do_flush();
    q0.push_back({FLIT_TYPE_HEADER, 16'h0F01});
    q0.push_back({FLIT_TYPE_LAST,   16'h0F02});
    q0.push_back({FLIT_TYPE_HEADER, 16'h0F11});
    q0.push_back({FLIT_TYPE_LAST,   16'h0F12});
    q0.push_back({FLIT_TYPE_HEADER, 16'h0F21});
    q0.push_back({FLIT_TYPE_LAST,   16'h0F22});
    q1.push_back({FLIT_TYPE_SINGLE, 16'h0F99});
    drain(50);
    exp = '{16'hDB00, 16'h0F01, 16'h0F02, 16'hDB01, 16'h0F99,
            16'hDB00, 16'h0F11, 16'h0F12, 16'hDB00, 16'h0F21, 16'h0F22};
    vectors++; if (outq.size() !== exp.size()) begin errors++; $display("FAIL fair_count: got %0d words, required %0d", outq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      vectors++; if (outq[i] !== exp[i]) begin errors++; $display("FAIL fair_word%0d: got %h, required %h", i, outq[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_proto_err();
    test_flush();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
